// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and FSM encoding for the LIF scheduler
package lif_pkg;

    localparam int LIF_WIDTH             = 8;
    localparam int LIF_DEFAULT_THRESHOLD = 200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_state_e;

endpackage

// File: rtl/lif_if.sv
// rtl/lif_if.sv - step handshake, config, spike and readout bundle
interface lif_if #(
    parameter int NUM_NEURONS = 8,
    parameter int WIDTH       = 8,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
);
    logic                         step_valid;
    logic                         step_ready;
    logic [NUM_NEURONS*WIDTH-1:0] currents;
    logic                         cfg_we;
    logic [WIDTH-1:0]             cfg_threshold;
    logic [NUM_NEURONS-1:0]       spikes;
    logic                         done;
    logic                         busy;
    logic [IDX_W-1:0]             rd_addr;
    logic [WIDTH-1:0]             rd_state;

    modport master (
        output step_valid, currents, cfg_we, cfg_threshold, rd_addr,
        input  step_ready, spikes, done, busy, rd_state
    );

    modport slave (
        input  step_valid, currents, cfg_we, cfg_threshold, rd_addr,
        output step_ready, spikes, done, busy, rd_state
    );
endinterface

// File: rtl/lif_update.sv
// rtl/lif_update.sv - one-neuron leaky integrate-and-fire update, combinational
module lif_update #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] state,
    input  logic             spk_prev,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] next,
    output logic             fire
);
    logic [WIDTH-1:0] leak;

    // A neuron that fired last step starts from zero instead of the halved membrane
    always_comb begin
        leak = spk_prev ? '0 : (state >> 1);
        next = current + leak;
        fire = (next >= threshold);
    end
endmodule

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - time-multiplexed LIF controller, one neuron per cycle
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS       = 8,
    parameter int WIDTH             = LIF_WIDTH,
    parameter int DEFAULT_THRESHOLD = LIF_DEFAULT_THRESHOLD,
    parameter int IDX_W             = $clog2(NUM_NEURONS)
) (
    input  logic   clk,
    input  logic   reset,
    lif_if.slave   bus
);
    lif_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [WIDTH-1:0]       cur_q [NUM_NEURONS];
    logic [WIDTH-1:0]       mem_q [NUM_NEURONS];
    logic [WIDTH-1:0]       thr_q, thr_snap_q;
    logic [NUM_NEURONS-1:0] spk_prev_q, spk_new_q, spk_new_d, spikes_q;
    logic [WIDTH-1:0]       rd_state_q;
    logic [WIDTH-1:0]       upd_next;
    logic                   upd_fire;
    logic                   accept;
    logic                   last_idx;

    assign last_idx     = (idx_q == IDX_W'(NUM_NEURONS - 1));
    assign bus.spikes   = spikes_q;
    assign bus.rd_state = rd_state_q;

    lif_update #(.WIDTH(WIDTH)) u_update (
        .current   (cur_q[idx_q]),
        .state     (mem_q[idx_q]),
        .spk_prev  (spk_prev_q[idx_q]),
        .threshold (thr_snap_q),
        .next      (upd_next),
        .fire      (upd_fire)
    );

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.step_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.step_ready = 1'b1;
                if (bus.step_valid) begin
                    accept  = 1'b1;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                bus.busy = 1'b1;
                if (last_idx) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spk_new_d        = spk_new_q;
        spk_new_d[idx_q] = upd_fire;
    end

    // Spike flags are published on the last update so they are already valid while done is high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            thr_q      <= WIDTH'(DEFAULT_THRESHOLD);
            thr_snap_q <= WIDTH'(DEFAULT_THRESHOLD);
            spk_prev_q <= '0;
            spk_new_q  <= '0;
            spikes_q   <= '0;
            rd_state_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_state_q <= mem_q[bus.rd_addr];
            if (bus.cfg_we) thr_q <= bus.cfg_threshold;
            if (accept) begin
                idx_q      <= '0;
                thr_snap_q <= thr_q;
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    cur_q[i] <= bus.currents[i*WIDTH +: WIDTH];
                end
            end
            if (state_q == ST_UPDATE) begin
                mem_q[idx_q] <= upd_next;
                spk_new_q    <= spk_new_d;
                idx_q        <= idx_q + IDX_W'(1);
                if (last_idx) begin
                    spikes_q   <= spk_new_d;
                    spk_prev_q <= spk_new_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - self-checking bench for lif_scheduler
module tb_lif_scheduler;
    localparam int N = 8;
    localparam int W = 8;

    logic clk;
    logic reset;

    lif_if #(.NUM_NEURONS(N), .WIDTH(W)) bus ();

    lif_scheduler #(.NUM_NEURONS(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int             m_mem [N];
    logic [N-1:0]   m_prev;
    logic [N-1:0]   m_spk;
    int             m_thr;

    typedef struct {
        logic [N*W-1:0] cur;
        int             exp_mem0;
        logic [N-1:0]   exp_spk;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rep(input int v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_cur();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, 255));
        return r;
    endfunction

    // Reference: membrane = current + half of old membrane unless it fired, modulo 256
    function automatic void model_step(input logic [N*W-1:0] cur, input int thr);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) begin
            int c;
            int nxt;
            c   = int'(cur[i*W +: W]);
            nxt = (c + (m_prev[i] ? 0 : m_mem[i] / 2)) % 256;
            m_mem[i] = nxt;
            s[i] = (nxt >= thr);
        end
        m_prev = s;
        m_spk  = s;
    endfunction

    task automatic do_reset();
        bus.step_valid = 1'b0;
        bus.cfg_we     = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_mem[i] = 0;
        m_prev = '0;
        m_spk  = '0;
        m_thr  = 200;
    endtask

    task automatic set_thr(input int v);
        bus.cfg_we        = 1'b1;
        bus.cfg_threshold = W'(v);
        tick();
        bus.cfg_we = 1'b0;
        m_thr = v;
    endtask

    task automatic read_mem(input int idx, output int val);
        bus.rd_addr = idx[$clog2(N)-1:0];
        tick();
        val = int'(bus.rd_state);
    endtask

    task automatic check_states(input string tag);
        int v;
        for (int i = 0; i < N; i++) begin
            read_mem(i, v);
            check($sformatf("%s_state[%0d]", tag, i), v, m_mem[i]);
        end
    endtask

    task automatic run_step(input logic [N*W-1:0] cur, input bit mid_cfg, input int mid_thr);
        int cyc;
        int snap;
        bus.currents   = cur;
        bus.step_valid = 1'b1;
        cyc = 0;
        while (!bus.step_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("ready_before_step", int'(bus.step_ready), 1);
        snap = m_thr;
        tick();
        bus.step_valid = 1'b0;
        check("busy_after_accept", int'(bus.busy), 1);
        cyc = 1;
        while (!bus.done && cyc < 50) begin
            if (mid_cfg && cyc == 3) begin
                bus.cfg_we        = 1'b1;
                bus.cfg_threshold = W'(mid_thr);
                m_thr = mid_thr;
            end
            tick();
            bus.cfg_we = 1'b0;
            cyc++;
        end
        check("done_latency", cyc, N + 1);
        model_step(cur, snap);
        check("spikes_at_done", int'(bus.spikes), int'(m_spk));
        tick();
        check("done_one_cycle", int'(bus.done), 0);
        check("ready_after_done", int'(bus.step_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        logic [N*W-1:0] cur;
        int v;
        int bad;
        int snap;
        int cyc;

        reset             = 1'b1;
        bus.step_valid    = 1'b0;
        bus.currents      = '0;
        bus.cfg_we        = 1'b0;
        bus.cfg_threshold = '0;
        bus.rd_addr       = '0;

        // Reset state
        do_reset();
        check("rst_spikes", int'(bus.spikes), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ready", int'(bus.step_ready), 1);
        check_states("rst");

        // Integration, leak, fire, leak suppression
        tbl[0] = '{rep(120), 120, 8'h00};
        tbl[1] = '{rep(120), 180, 8'h00};
        tbl[2] = '{rep(120), 210, 8'hFF};
        tbl[3] = '{rep(120), 120, 8'h00};
        tbl[4] = '{rep(120), 180, 8'h00};
        for (int k = 0; k < 5; k++) begin
            run_step(tbl[k].cur, 1'b0, 0);
            check($sformatf("tbl%0d_spikes", k), int'(bus.spikes), int'(tbl[k].exp_spk));
            read_mem(0, v);
            check($sformatf("tbl%0d_mem0", k), v, tbl[k].exp_mem0);
            check_states($sformatf("tbl%0d", k));
        end

        // Modulo wrap
        do_reset();
        set_thr(255);
        cur = '0;
        cur[W-1:0] = W'(200);
        run_step(cur, 1'b0, 0);
        read_mem(0, v);
        check("wrap_mem0_a", v, 200);
        check("wrap_spikes_a", int'(bus.spikes), 0);
        run_step(cur, 1'b0, 0);
        read_mem(0, v);
        check("wrap_mem0_b", v, 44);
        check("wrap_spikes_b", int'(bus.spikes), 0);
        check_states("wrap");

        // Handshake: step_valid held high across a whole step
        do_reset();
        cur = rand_cur();
        bus.currents   = cur;
        bus.step_valid = 1'b1;
        check("hs_ready_idle", int'(bus.step_ready), 1);
        snap = m_thr;
        tick();
        bad = 0;
        for (int c = 1; c <= N + 1; c++) begin
            if (bus.step_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            if (bus.done !== (c == N + 1)) bad++;
            if (c < N + 1) tick();
        end
        check("hs_busy_window", bad, 0);
        model_step(cur, snap);
        check("hs_spikes1", int'(bus.spikes), int'(m_spk));
        tick();
        check("hs_reaccept_at_10", int'(bus.step_ready), 1);
        snap = m_thr;
        tick();
        bus.step_valid = 1'b0;
        check("hs_second_busy", int'(bus.busy), 1);
        cyc = 1;
        while (!bus.done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("hs_done_latency2", cyc, N + 1);
        model_step(cur, snap);
        check("hs_spikes2", int'(bus.spikes), int'(m_spk));
        tick();
        check_states("hs");

        // Threshold write during UPDATE applies from the next step
        do_reset();
        run_step(rep(150), 1'b1, 100);
        check("cfg_mid_spikes_a", int'(bus.spikes), 0);
        run_step(rep(150), 1'b0, 0);
        check("cfg_mid_spikes_b", int'(bus.spikes), 8'hFF);
        read_mem(0, v);
        check("cfg_mid_mem0", v, 225);

        // Reset at the 4th UPDATE cycle abandons the step
        do_reset();
        bus.currents   = rep(250);
        bus.step_valid = 1'b1;
        tick();
        bus.step_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_mem[i] = 0;
        m_prev = '0;
        m_spk  = '0;
        m_thr  = 200;
        check("rstmid_ready", int'(bus.step_ready), 1);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done !== 1'b0) bad++;
            tick();
        end
        check("rstmid_no_done", bad, 0);
        check("rstmid_spikes", int'(bus.spikes), 0);
        check_states("rstmid");

        // Threshold 0: everything fires
        set_thr(0);
        run_step(rand_cur(), 1'b0, 0);
        check("thr0_spikes", int'(bus.spikes), 8'hFF);

        // Randomized steps against the reference model
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) set_thr($urandom_range(0, 255));
            run_step(rand_cur(), ($urandom_range(0, 4) == 0), $urandom_range(0, 255));
            check_states($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed controller for the leaky integrate-and-fire update. It owns the membrane state of NUM_NEURONS neurons and runs one shared update datapath over them, one neuron per cycle, on every accepted timestep request. It also owns the firing threshold and the previous-step spike flags that suppress the leak term. It sits between the input-current source and the spike consumer.

## Interface

Parameters:
- NUM_NEURONS, 8, neurons sharing the datapath (≥2)
- WIDTH, 8, membrane/current width
- DEFAULT_THRESHOLD, 200, threshold after reset
- IDX_W, $clog2(NUM_NEURONS), neuron index width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- step_valid  in  1  timestep request
- step_ready  out  1  high only in IDLE
- currents  in  NUM_NEURONS*WIDTH  packed currents; neuron i at [i*WIDTH +: WIDTH]
- cfg_we  in  1  threshold write strobe
- cfg_threshold  in  WIDTH  new threshold
- spikes  out  NUM_NEURONS  spike vector of last completed step
- done  out  1  one-cycle pulse, step complete
- busy  out  1  high in UPDATE and DONE
- rd_addr  in  IDX_W  membrane readout index
- rd_state  out  WIDTH  membrane of neuron rd_addr, registered

## Operation

- FSM states: IDLE, UPDATE, DONE.
- IDLE: step_ready=1. On step_valid, capture currents and snapshot the active threshold, clear idx, go to UPDATE.
- UPDATE: one neuron per cycle, for idx = 0 … NUM_NEURONS-1:
  - next = current[idx] + (spk_prev[idx] ? 0 : state[idx] >> 1), modulo 2^WIDTH. Wrap, no saturation.
  - Write state[idx] = next.
  - Write spk_new[idx] = (next >= threshold snapshot), unsigned compare.
  - After the last idx, go to DONE.
- DONE: spikes ← spk_new, spk_prev ← spk_new, done=1, then go to IDLE.
- cfg_we is accepted in any state and updates the active threshold. A step uses the value snapshotted at acceptance, so a mid-step write applies from the next step.
- step_valid outside IDLE is ignored; no queuing.
- Readout: rd_state ← state[rd_addr] each cycle. A neuron written in cycle t is visible in rd_state at t+2.
- Reset values:
  - all state = 0, spk_prev = 0, spikes = 0
  - threshold = DEFAULT_THRESHOLD, FSM = IDLE
  - done = 0, busy = 0, step_ready = 1, rd_state = 0
- Reset mid-step: abandon the step. No done pulse, and spikes is not updated.
- Threshold 0: every neuron spikes every step.

## Timing

- Acceptance in cycle A (step_valid & step_ready) → UPDATE in cycles A+1 … A+NUM_NEURONS → done high in cycle A+NUM_NEURONS+1. spikes is valid from that same cycle and holds until the next DONE.
- step_ready returns high in cycle A+NUM_NEURONS+2. Back-to-back steps occur at a period of NUM_NEURONS+2 cycles.
- busy covers exactly cycles A+1 … A+NUM_NEURONS+1.
- cfg_we & step acceptance in the same cycle: the step uses the old threshold, and the new one is active afterwards.

## Structure

- Shared package lif_pkg:
  - WIDTH default
  - FSM state enum (IDLE, UPDATE, DONE)
  - DEFAULT_THRESHOLD constant
- Sub-module lif_update (combinational), one instance:
  - inputs: current, state, spk_prev, threshold
  - outputs: next, fire
- The scheduler holds the FSM, index counter, current capture, state array, spike flags and readout register.

## Test plan

- Reset: apply reset for 2 cycles. Require spikes=0, done=0, busy=0, step_ready=1, rd_state=0 for every rd_addr.
- Integration/leak/fire: threshold 200, all currents 120, five steps.
  - Required membrane per step: 120, 180, 210 (spike), 120 (leak suppressed, no spike), 180.
  - spikes=0xFF only after step 3.
- Wrap: threshold 255, neuron 0 current 200, others 0, two steps.
  - Required state[0]: 200, then 44. No spikes.
  - Other neurons stay 0.
- Handshake/latency: NUM_NEURONS=8.
  - Require done exactly 9 cycles after acceptance.
  - step_valid held high while busy starts no new step.
  - Next acceptance occurs 10 cycles after the first.
- Config mid-step: write threshold 100 during UPDATE of a step with currents 150 and old threshold 200.
  - That step gives spikes=0.
  - The next step (membrane 225) gives spikes=0xFF.
- Reset mid-step: assert reset at the 4th UPDATE cycle.
  - No done pulse.
  - All state reads back 0; spikes=0.
  - step_ready=1 on the cycle after reset deasserts.
